audio_sample_sink: RTL and testbench

AUDIO_SAMPLE_SINK -- requirements
Module: audio_sample_sink

---
 rtl/audio_sample_sink.sv | 173 +++++++++++++++++
 tb/tb_audio_sample_sink.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_sink.sv
`default_nettype none
// ============================================================================
// Module      : audio_sample_sink
// Description : Accepts 32-bit flash words carrying two signed 16-bit samples,
//               attenuates each sample by a power of two (signed, truncating
//               toward zero) and queues them in a small FIFO. A three-state
//               handshake FSM then feeds the samples one at a time to an audio
//               codec using a write_ready / write_s strobe protocol.
// Optional    : `define VOLUME_CTRL_EN adds the vol_shift port, which replaces
//               the fixed ATTEN_SHIFT exponent and is sampled at push time.
// Ports       : CLOCK_50        - clock, rising edge
//               rst_n           - synchronous active-low reset
//               in_valid/in_ready/in_data - upstream word handshake
//               write_ready     - codec can accept a sample
//               write_s         - codec write strobe
//               writedata_left/right - sample to codec (identical channels)
//               fifo_level      - FIFO occupancy in samples
//               underrun        - sticky: codec ready while FIFO empty
//               vol_shift       - runtime attenuation exponent (option only)
// Revision    : 1.0 - initial release
// ============================================================================
module audio_sample_sink #(
  parameter int DEPTH       = 8,  // power of two, at least 4
  parameter int ATTEN_SHIFT = 6
) (
  input  logic                   CLOCK_50,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [31:0]            in_data,
  output logic                   in_ready,
  input  logic                   write_ready,
  output logic                   write_s,
  output logic [15:0]            writedata_left,
  output logic [15:0]            writedata_right,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   underrun
`ifdef VOLUME_CTRL_EN
  ,
  input  logic [3:0]             vol_shift
`endif
);

  localparam int                c_aw        = $clog2(DEPTH);
  localparam int                c_lw        = c_aw + 1;
  localparam logic [c_aw-1:0]   c_ptr_one   = c_aw'(1);
  localparam logic [c_aw-1:0]   c_ptr_two   = c_aw'(2);
  localparam logic [c_lw-1:0]   c_lvl_one   = c_lw'(1);
  localparam logic [c_lw-1:0]   c_lvl_two   = c_lw'(2);
  localparam logic [c_lw-1:0]   c_lvl_depth = c_lw'(DEPTH);
`ifndef VOLUME_CTRL_EN
  localparam logic [3:0]        c_atten     = 4'(ATTEN_SHIFT);
`endif

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RDY = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_aw-1:0]   r_wptr;
  logic [c_aw-1:0]   r_rptr;
  logic [c_lw-1:0]   r_level;
  logic [c_lw-1:0]   w_free;
  logic [15:0]       r_mem [DEPTH];
  logic [15:0]       r_data;
  logic              r_write_s;
  logic              r_underrun;
  logic              r_ever_written;
  logic              w_push;
  logic              w_pop;
  logic [3:0]        w_shift;
  logic [15:0]       w_att_lo;
  logic [15:0]       w_att_hi;

  // Signed divide by 2^n rounding toward zero: negative values get a bias of
  // 2^n-1 before the arithmetic shift so that the shift no longer rounds down.
  function automatic logic [15:0] f_atten(input logic [15:0] x, input logic [3:0] n);
    logic        [16:0] w_bias;
    logic signed [16:0] w_sum;
    w_bias = x[15] ? ((17'd1 << n) - 17'd1) : 17'd0;
    w_sum  = $signed({x[15], x}) + $signed(w_bias);
    w_sum  = w_sum >>> n;
    return w_sum[15:0];
  endfunction

`ifdef VOLUME_CTRL_EN
  assign w_shift = vol_shift;
`else
  assign w_shift = c_atten;
`endif

  assign w_att_lo = f_atten(in_data[15:0], w_shift);
  assign w_att_hi = f_atten(in_data[31:16], w_shift);

  // Each accepted word needs two free slots; gating on that means the FIFO
  // can never overflow even when a pop happens in the same cycle.
  assign w_free   = c_lvl_depth - r_level;
  assign in_ready = (w_free >= c_lvl_two);
  assign w_push   = in_valid && in_ready;

  // FSM next state and pop decision
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_level != '0) w_state_nxt = WAIT_RDY;
      end
      WAIT_RDY: begin
        if (write_ready) begin
          w_pop       = 1'b1;
          w_state_nxt = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        // r_level already reflects the pop made on entry to this state
        if (!write_ready) w_state_nxt = (r_level != '0) ? WAIT_RDY : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Sample storage carries no reset; the pointers define what is valid.
  always_ff @(posedge CLOCK_50) begin
    if (w_push) begin
      r_mem[r_wptr]             <= w_att_lo;
      r_mem[r_wptr + c_ptr_one] <= w_att_hi;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_level        <= '0;
      r_data         <= '0;
      r_write_s      <= 1'b0;
      r_underrun     <= 1'b0;
      r_ever_written <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_ptr_two;
      if (w_pop) begin
        r_rptr         <= r_rptr + c_ptr_one;
        r_data         <= r_mem[r_rptr];
        r_write_s      <= 1'b1;
        r_ever_written <= 1'b1;
      end else if (r_state == WAIT_LOW && !write_ready) begin
        r_write_s <= 1'b0;
      end
      r_level <= r_level + (w_push ? c_lvl_two : '0) - (w_pop ? c_lvl_one : '0);
      if (r_state == IDLE && write_ready && r_level == '0 && r_ever_written)
        r_underrun <= 1'b1;
    end
  end

  assign write_s         = r_write_s;
  assign writedata_left  = r_data;
  assign writedata_right = r_data;
  assign fifo_level      = r_level;
  assign underrun        = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_audio_sample_sink.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_sample_sink
// Description : Self-checking bench for audio_sample_sink. A queue-based
//               reference model predicts every output each cycle; directed
//               sequences cover latency, fill/drain, reset mid-handshake and
//               attenuation extremes, followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_sample_sink;

  localparam int DEPTH       = 8;
  localparam int ATTEN_SHIFT = 6;

  logic        CLOCK_50;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        write_ready;
  logic        write_s;
  logic [15:0] writedata_left;
  logic [15:0] writedata_right;
  logic [3:0]  fifo_level;
  logic        underrun;
  logic [3:0]  vol_shift;

  audio_sample_sink #(.DEPTH(DEPTH), .ATTEN_SHIFT(ATTEN_SHIFT)) dut (
    .CLOCK_50       (CLOCK_50),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .write_ready    (write_ready),
    .write_s        (write_s),
    .writedata_left (writedata_left),
    .writedata_right(writedata_right),
    .fifo_level     (fifo_level),
    .underrun       (underrun)
`ifdef VOLUME_CTRL_EN
    ,
    .vol_shift      (vol_shift)
`endif
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #10 CLOCK_50 = ~CLOCK_50;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [15:0] q[$];
  int          m_phase;   // 0 idle, 1 waiting for ready, 2 strobe held
  bit          m_ws;
  logic [15:0] m_out;
  bit          m_under;
  bit          m_ever;
  int          m_words;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_atten(input logic [15:0] s, input int n);
    int x;
    x = int'($signed(s));
    return 16'(x / (1 << n));
  endfunction

  function automatic int cur_shift();
`ifdef VOLUME_CTRL_EN
    return int'(vol_shift);
`else
    return ATTEN_SHIFT;
`endif
  endfunction

  task automatic model_step();
    int lvl;
    bit rdy;
    if (!rst_n) begin
      q.delete();
      m_phase = 0;
      m_ws    = 0;
      m_out   = '0;
      m_under = 0;
      m_ever  = 0;
      return;
    end
    lvl = q.size();
    rdy = (DEPTH - lvl) >= 2;
    if (m_phase == 0 && write_ready && lvl == 0 && m_ever) m_under = 1;
    case (m_phase)
      0: if (lvl != 0) m_phase = 1;
      1: if (write_ready) begin
           m_out   = q.pop_front();
           m_ws    = 1;
           m_ever  = 1;
           m_phase = 2;
         end
      default: if (!write_ready) begin
           m_ws    = 0;
           m_phase = (lvl != 0) ? 1 : 0;
         end
    endcase
    if (in_valid && rdy) begin
      q.push_back(ref_atten(in_data[15:0], cur_shift()));
      q.push_back(ref_atten(in_data[31:16], cur_shift()));
      m_words++;
    end
  endtask

  task automatic compare_all();
    check("fifo_level", 32'(fifo_level), 32'(q.size()));
    check("in_ready", 32'(in_ready), 32'((DEPTH - q.size()) >= 2));
    check("write_s", 32'(write_s), 32'(m_ws));
    check("writedata_left", 32'(writedata_left), 32'(m_out));
    check("writedata_right", 32'(writedata_right), 32'(m_out));
    check("underrun", 32'(underrun), 32'(m_under));
  endtask

  task automatic drive_cycle(input bit rn, input bit v, input logic [31:0] d, input bit wr);
    @(negedge CLOCK_50);
    rst_n       = rn;
    in_valid    = v;
    in_data     = d;
    write_ready = wr;
    @(posedge CLOCK_50);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    drive_cycle(0, 0, 32'h0, 0);
    drive_cycle(0, 0, 32'h0, 0);
  endtask

  // Push one word with write_ready high, then collect both samples
  task automatic two_sample_run(input logic [31:0] w, input logic [15:0] e0, input logic [15:0] e1,
                                input string tag);
    do_reset();
    drive_cycle(1, 1, w, 1);
    drive_cycle(1, 0, 32'h0, 1);
    drive_cycle(1, 0, 32'h0, 1);
    check({tag, "_first"}, 32'(writedata_left), 32'(e0));
    check({tag, "_first_ws"}, 32'(write_s), 32'd1);
    drive_cycle(1, 0, 32'h0, 0);
    drive_cycle(1, 0, 32'h0, 1);
    check({tag, "_second"}, 32'(writedata_left), 32'(e1));
    drive_cycle(1, 0, 32'h0, 0);
  endtask

  initial begin
    int words_before;
    rst_n = 0; in_valid = 0; in_data = '0; write_ready = 0; vol_shift = 4'd6;
    m_phase = 0; m_ws = 0; m_out = '0; m_under = 0; m_ever = 0; m_words = 0;

    // Reset state and ready right after release
    do_reset();
    check("reset_level", 32'(fifo_level), 32'd0);
    drive_cycle(1, 0, 32'h0, 0);
    check("ready_after_reset", 32'(in_ready), 32'd1);

    // Basic latency / order / underrun
    two_sample_run(32'h0040FFC0, 16'hFFFF, 16'h0001, "basic");
    check("underrun_before_idle_ready", 32'(underrun), 32'd0);
    drive_cycle(1, 0, 32'h0, 1);
    check("underrun_set", 32'(underrun), 32'd1);
    drive_cycle(1, 0, 32'h0, 1);
    check("underrun_sticky", 32'(underrun), 32'd1);

    // Attenuation extremes
    two_sample_run(32'h80007FFF, 16'd511, 16'hFE00, "extreme");
`ifdef VOLUME_CTRL_EN
    vol_shift = 4'd0;
    two_sample_run(32'h80007FFF, 16'h7FFF, 16'h8000, "passthru");
    vol_shift = 4'd6;
`endif

    // Fill with codec stalled
    do_reset();
    words_before = m_words;
    for (int i = 0; i < 8; i++) drive_cycle(1, 1, $urandom, 0);
    check("fill_words", 32'(m_words - words_before), 32'd4);
    check("fill_level", 32'(fifo_level), 32'd8);
    check("fill_ready", 32'(in_ready), 32'd0);

    // Pulsed write_ready while upstream keeps offering
    for (int p = 0; p < 6; p++) begin
      drive_cycle(1, 1, $urandom, 1);
      for (int k = 0; k < 3; k++) drive_cycle(1, 1, $urandom, 0);
    end
    // Drain, then check every sample survived in order
    for (int i = 0; i < 40; i++) drive_cycle(1, 0, 32'h0, (i % 2) == 0);
    check("drained_level", 32'(fifo_level), 32'd0);

    // Reset while strobe held with five entries queued
    do_reset();
    for (int i = 0; i < 3; i++) drive_cycle(1, 1, $urandom, 0);
    drive_cycle(1, 0, 32'h0, 1);
    check("pre_reset_level", 32'(fifo_level), 32'd5);
    check("pre_reset_ws", 32'(write_s), 32'd1);
    drive_cycle(0, 0, 32'h0, 1);
    check("mid_reset_ws", 32'(write_s), 32'd0);
    check("mid_reset_level", 32'(fifo_level), 32'd0);
    check("mid_reset_data", 32'(writedata_left), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
`ifdef VOLUME_CTRL_EN
      vol_shift = 4'($urandom_range(0, 15));
`endif
      drive_cycle(($urandom_range(0, 399) != 0), $urandom_range(0, 1), $urandom,
                  ($urandom_range(0, 2) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
